// File: rtl/float_add_sequencer_pkg.sv
// floatingpoint: shared float type, quiet-NaN constant and add-sequencer state encoding.
package floatingpoint;

    typedef logic [31:0] float;

    localparam float FLOAT_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fadd_seq_state_t;

    function automatic logic is_zero(input float f);
        return f[30:0] == 31'b0;
    endfunction

endpackage

// File: rtl/float_add_sequencer_fifo.sv
// float_op_fifo: synchronous operand-pair FIFO with wrap-bit pointers; head is shown combinationally.
module float_op_fifo
    import floatingpoint::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   push,
    input  float                   push_op1,
    input  float                   push_op2,
    input  logic [TAG_W-1:0]       push_tag,
    input  logic                   pop,
    output float                   head_op1,
    output float                   head_op2,
    output logic [TAG_W-1:0]       head_tag,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        float             op1;
        float             op2;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = wr_ptr == rd_ptr;
    assign {head_op1, head_op2, head_tag} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clock)
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= '{push_op1, push_op2, push_tag};

    always_ff @(posedge Clock)
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end

endmodule

// File: rtl/float_add_sequencer.sv
// float_add_sequencer: queues operand pairs and issues them one at a time to the FloatAdder, with watchdog.
// Optional FADD_ZERO_BYPASS_EN: operations with a +-0 operand skip the adder.
module float_add_sequencer
    import floatingpoint::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  float             InOp1,
    input  float             InOp2,
    input  logic [TAG_W-1:0] InTag,
    output float             AddOp1,
    output float             AddOp2,
    output logic             AddInputValid,
    input  float             AddResult,
    input  logic             AddResultValid,
    output logic             OutValid,
    input  logic             OutReady,
    output float             OutResult,
    output logic [TAG_W-1:0] OutTag,
    output logic             Busy,
    output logic             Error
);
    localparam int CW = $clog2(TIMEOUT + 1);

    fadd_seq_state_t state, state_next;
    float op1, op2, head_op1, head_op2, bypass_result;
    logic [TAG_W-1:0] head_tag;
    logic [CW-1:0] wd_count;
    logic [$clog2(DEPTH):0] count;
    logic push, pop, full, empty, expire, bypass, pending;

    float_op_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) fifo (
        .Clock, .Reset, .push,
        .push_op1(InOp1), .push_op2(InOp2), .push_tag(InTag),
        .pop, .head_op1, .head_op2, .head_tag,
        .full, .empty, .count
    );

    assign InReady   = !full;
    assign push      = InValid && !full;
    assign pending   = !empty || push;
    assign Busy      = count != '0 || state != IDLE;
    assign OutValid  = state == DONE;
    assign expire    = state == WAIT && !AddResultValid && wd_count == CW'(TIMEOUT - 1);
    // Operands come straight from the FIFO head during the issue pulse, then from the held copy.
    assign AddOp1    = state == ISSUE ? head_op1 : op1;
    assign AddOp2    = state == ISSUE ? head_op2 : op2;

`ifdef FADD_ZERO_BYPASS_EN
    logic z1, z2;
    assign z1 = is_zero(head_op1);
    assign z2 = is_zero(head_op2);
    assign bypass = state == ISSUE && (z1 || z2);
    assign bypass_result = z1 && z2 ? {head_op1[31] & head_op2[31], 31'b0} : z1 ? head_op2 : head_op1;
`else
    assign bypass = 1'b0;
    assign bypass_result = '0;
`endif

    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        AddInputValid = 1'b0;
        case (state)
            IDLE:  state_next = pending ? ISSUE : IDLE;
            ISSUE: begin
                pop           = 1'b1;
                AddInputValid = !bypass;
                state_next    = bypass ? DONE : WAIT;
            end
            WAIT:  state_next = AddResultValid || expire ? DONE : WAIT;
            DONE:  state_next = !OutReady ? DONE : pending ? ISSUE : IDLE;
        endcase
    end

    always_ff @(posedge Clock)
        if (Reset) begin
            state     <= IDLE;
            op1       <= '0;
            op2       <= '0;
            OutTag    <= '0;
            OutResult <= '0;
            wd_count  <= '0;
            Error     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ISSUE) begin
                op1      <= head_op1;
                op2      <= head_op2;
                OutTag   <= head_tag;
                wd_count <= '0;
                if (bypass)
                    OutResult <= bypass_result;
            end
            if (state == WAIT) begin
                wd_count <= wd_count + 1'b1;
                if (AddResultValid)
                    OutResult <= AddResult;
                else if (expire) begin
                    OutResult <= FLOAT_QNAN;
                    Error     <= 1'b1;
                end
            end
        end

endmodule

// File: tb/tb_float_add_sequencer.sv
// tb_float_add_sequencer: directed checks of issue timing, backpressure, ordering, watchdog and reset.
module tb_float_add_sequencer;
    logic        Clock = 1'b0, Reset = 1'b1;
    logic        InValid = 1'b0, InReady;
    logic [31:0] InOp1 = '0, InOp2 = '0;
    logic [3:0]  InTag = '0;
    logic [31:0] AddOp1, AddOp2, AddResult = '0;
    logic        AddInputValid, AddResultValid = 1'b0;
    logic        OutValid, OutReady = 1'b0;
    logic [31:0] OutResult;
    logic [3:0]  OutTag;
    logic        Busy, Error;
    int checks = 0, errors = 0, pulses;

    float_add_sequencer dut (
        .Clock, .Reset, .InValid, .InReady, .InOp1, .InOp2, .InTag,
        .AddOp1, .AddOp2, .AddInputValid, .AddResult, .AddResultValid,
        .OutValid, .OutReady, .OutResult, .OutTag, .Busy, .Error
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        InValid = 1'b1; InOp1 = a; InOp2 = b; InTag = t;
    endtask

    initial begin
        tick(); tick();
        chk("rst_inready", InReady, 1);
        chk("rst_addvalid", AddInputValid, 0);
        chk("rst_addop1", AddOp1, 0);
        chk("rst_addop2", AddOp2, 0);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_outresult", OutResult, 0);
        chk("rst_outtag", OutTag, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_error", Error, 0);
        Reset = 1'b0;
        tick();

        // basic operation, adder answers 6 cycles after the issue pulse
        push(32'h3F80_0000, 32'h4000_0000, 4'd3);
        tick();
        InValid = 1'b0;
        chk("t1_issue_pulse", AddInputValid, 1);
        chk("t1_issue_op1", AddOp1, 32'h3F80_0000);
        chk("t1_issue_op2", AddOp2, 32'h4000_0000);
        pulses = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(AddInputValid);
        end
        chk("t1_wait_op1_held", AddOp1, 32'h3F80_0000);
        chk("t1_wait_op2_held", AddOp2, 32'h4000_0000);
        tick();
        pulses += int'(AddInputValid);
        AddResultValid = 1'b1; AddResult = 32'h4040_0000;
        chk("t1_outvalid_early", OutValid, 0);
        tick();
        AddResultValid = 1'b0;
        chk("t1_single_pulse", pulses, 1);
        chk("t1_outvalid", OutValid, 1);
        chk("t1_outresult", OutResult, 32'h4040_0000);
        chk("t1_outtag", OutTag, 3);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        chk("t1_idle_outvalid", OutValid, 0);
        chk("t1_idle_busy", Busy, 0);

        // park one result in DONE, then overfill the FIFO behind it
        push(32'h4000_0000, 32'h4000_0000, 4'd9);
        tick();
        InValid = 1'b0;
        tick();
        AddResultValid = 1'b1; AddResult = 32'h4080_0000;
        tick();
        AddResultValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(32'h4100_0000 + i, 32'h3F80_0000, 4'(i));
            chk($sformatf("t2_inready_%0d", i), InReady, i < 4);
            tick();
        end
        InValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_outvalid", OutValid, 1);
            chk("t3_hold_result", OutResult, 32'h4080_0000);
            chk("t3_hold_tag", OutTag, 9);
            chk("t3_no_issue", AddInputValid, 0);
            tick();
        end
        chk("t2_full_busy", Busy, 1);
        OutReady = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            OutReady = 1'b0;
            chk($sformatf("t2_issue_%0d", j), AddInputValid, 1);
            chk($sformatf("t2_op1_%0d", j), AddOp1, 32'h4100_0000 + j);
            tick();
            AddResultValid = 1'b1; AddResult = 32'h4200_0000 + j;
            chk($sformatf("t2_held_%0d", j), AddOp1, 32'h4100_0000 + j);
            tick();
            AddResultValid = 1'b0;
            chk($sformatf("t2_outvalid_%0d", j), OutValid, 1);
            chk($sformatf("t2_result_%0d", j), OutResult, 32'h4200_0000 + j);
            chk($sformatf("t2_tag_%0d", j), OutTag, j);
            OutReady = 1'b1;
        end
        tick();
        OutReady = 1'b0;
        chk("t2_drained_busy", Busy, 0);
        chk("t2_drained_outvalid", OutValid, 0);

        // adder answers on the very cycle the watchdog would expire
        push(32'h1, 32'h2, 4'd7);
        tick();
        InValid = 1'b0;
        repeat (64) tick();
        AddResultValid = 1'b1; AddResult = 32'h2222_2222;
        tick();
        AddResultValid = 1'b0;
        chk("race_outvalid", OutValid, 1);
        chk("race_result", OutResult, 32'h2222_2222);
        chk("race_error", Error, 0);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;

        // adder never answers
        push(32'h3F80_0000, 32'h3F80_0000, 4'd5);
        tick();
        InValid = 1'b0;
        repeat (64) tick();
        chk("wd_not_yet", OutValid, 0);
        chk("wd_error_not_yet", Error, 0);
        tick();
        chk("wd_outvalid", OutValid, 1);
        chk("wd_error", Error, 1);
        chk("wd_qnan", OutResult, 32'h7FC0_0000);
        chk("wd_tag", OutTag, 5);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        push(32'h4000_0000, 32'h3F80_0000, 4'd6);
        tick();
        InValid = 1'b0;
        chk("wd_next_issue", AddInputValid, 1);
        tick();
        AddResultValid = 1'b1; AddResult = 32'h4040_0000;
        tick();
        AddResultValid = 1'b0;
        chk("wd_next_result", OutResult, 32'h4040_0000);
        chk("wd_next_tag", OutTag, 6);
        chk("wd_error_sticky", Error, 1);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;

        // reset while waiting with three entries queued
        for (int i = 1; i <= 4; i++) begin
            push(32'h5000_0000 + i, 32'h3F80_0000, 4'(i));
            tick();
        end
        InValid = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rw_outvalid", OutValid, 0);
        chk("rw_busy", Busy, 0);
        chk("rw_inready", InReady, 1);
        chk("rw_error", Error, 0);
        AddResultValid = 1'b1; AddResult = 32'h3333_3333;
        tick();
        AddResultValid = 1'b0;
        tick();
        chk("rw_late_outvalid", OutValid, 0);
        chk("rw_late_busy", Busy, 0);
        chk("rw_late_addvalid", AddInputValid, 0);

`ifdef FADD_ZERO_BYPASS_EN
        push(32'h8000_0000, 32'hC0A0_0000, 4'd2);
        tick();
        InValid = 1'b0;
        chk("bp_no_pulse", AddInputValid, 0);
        tick();
        chk("bp_outvalid", OutValid, 1);
        chk("bp_result", OutResult, 32'hC0A0_0000);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        push(32'h8000_0000, 32'h8000_0000, 4'd4);
        tick();
        InValid = 1'b0;
        tick();
        chk("bp_negzero", OutResult, 32'h8000_0000);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
